// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder controller. One shared digit adder processes
// operands least-significant digit first, with a start/busy/done handshake.

module bcd_digit_add (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] t;
  always_comb begin
    t  = {1'b0, x} + {1'b0, y} + {4'b0, cin};
    s  = t[3:0];
    co = 1'b0;
    if (t > 5'd9) begin
      s  = t[3:0] + 4'd6;   // decimal correction, wraps mod 16
      co = 1'b1;
    end
  end
endmodule

module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                invalid
);
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nxt;

  logic [4*DIGITS-1:0] a_sr, b_sr;
  logic [CW-1:0]       cnt;
  logic                carry;
  logic                bad, accept, last;
  logic [3:0]          dig;
  logic                dco;

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad = 1'b1;
  end

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (cnt == CW'(DIGITS - 1));

  bcd_digit_add u_dadd (
    .x  (a_sr[3:0]),
    .y  (b_sr[3:0]),
    .cin(carry),
    .s  (dig),
    .co (dco)
  );

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (start) nxt = bad ? DONE : RUN;
      RUN:  if (last)  nxt = DONE;
      DONE: nxt = start ? (bad ? DONE : RUN) : IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Operands are captured at accept and shifted, so host changes during RUN
  // never reach the adder.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      invalid <= 1'b0;
    end else if (accept) begin
      a_sr    <= a;
      b_sr    <= b;
      cnt     <= '0;
      carry   <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      invalid <= bad;
    end else if (state == RUN) begin
      a_sr  <= a_sr >> 4;
      b_sr  <= b_sr >> 4;
      carry <= dco;
      cnt   <= last ? '0 : cnt + CW'(1);
      for (int i = 0; i < DIGITS; i++)
        if (cnt == CW'(i)) sum[4*i +: 4] <= dig;
      if (last) cout <= dco;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Scoreboard bench for bcd_serial_add_ctrl: expected results queued at launch,
// checked whenever done is observed.
module tb_bcd_serial_add_ctrl;
  localparam int DIGITS = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        busy, done, cout, invalid;
  logic [15:0] sum;

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .invalid(invalid)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] s; logic c; logic inv; } exp_t;
  exp_t sbq[$];
  int   nchk = 0, nfail = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent reference: decimal value arithmetic, not digit-serial.
  function automatic logic [16:0] ref_add(input logic [15:0] x, input logic [15:0] y);
    int s = 0, p = 1;
    logic [15:0] r = '0;
    logic [3:0]  d;
    for (int i = 0; i < DIGITS; i++) begin
      s += (int'(x[4*i +: 4]) + int'(y[4*i +: 4])) * p;
      p *= 10;
    end
    for (int i = 0; i < DIGITS; i++) begin
      d = 4'((s / (10 ** i)) % 10);
      r[4*i +: 4] = d;
    end
    return {(s >= p), r};
  endfunction

  function automatic logic [15:0] rnd_bcd();
    logic [15:0] r;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy_done_excl", {31'b0, busy & done}, 32'd0);
      if (done) begin
        if (sbq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = sbq.pop_front();
          chk("sum",     {16'b0, sum},         {16'b0, e.s});
          chk("cout",    {31'b0, cout},        {31'b0, e.c});
          chk("invalid", {31'b0, invalid},     {31'b0, e.inv});
        end
      end
    end
  end

  task automatic wait_done(output int n);
    int k;
    n = 0;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) break;
      if (busy) n++;
    end
    if (k == 40) chk("timeout", 32'd1, 32'd0);
  endtask

  task automatic run_add(input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] es, input logic ec, input logic ei,
                         input int lat);
    int n;
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    sbq.push_back('{s: es, c: ec, inv: ei});
    wait_done(n);
    chk("latency", n, lat);
  endtask

  initial begin
    logic [16:0] r;
    logic [15:0] x, y;
    int n;
    repeat (3) @(negedge clk);
    chk("rst_sum",  {16'b0, sum}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_cout_inv", {30'b0, cout, invalid}, 32'd0);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    run_add(16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0, DIGITS);
    repeat (2) @(negedge clk);
    chk("hold_sum", {16'b0, sum}, 32'h6912);
    chk("idle_busy_done", {30'b0, busy, done}, 32'd0);

    run_add(16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0, DIGITS);
    run_add(16'h9999, 16'h9999, 16'h9998, 1'b1, 1'b0, DIGITS);
    run_add(16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1, 0);
    run_add(16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, DIGITS);

    // start held high through RUN with operand changes; relaunch from DONE
    @(negedge clk);
    a = 16'h0500; b = 16'h0500; start = 1'b1;
    sbq.push_back('{s: 16'h1000, c: 1'b0, inv: 1'b0});
    sbq.push_back('{s: 16'h0010, c: 1'b0, inv: 1'b0});
    @(negedge clk);
    chk("held_busy", {31'b0, busy}, 32'd1);
    a = 16'h0005; b = 16'h0005;
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("held_done", {31'b0, done}, 32'd1);
    @(negedge clk);
    chk("b2b_busy", {31'b0, busy}, 32'd1);
    start = 1'b0;
    wait_done(n);
    chk("b2b_latency", n, DIGITS - 1);

    // reset mid-RUN: no result, no done
    @(negedge clk);
    a = 16'h4321; b = 16'h1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_sum",  {16'b0, sum}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_flags", {30'b0, cout, invalid}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_idle", {30'b0, busy, done}, 32'd0);
    run_add(16'h0001, 16'h0009, 16'h0010, 1'b0, 1'b0, DIGITS);

    for (int t = 0; t < 6; t++) begin
      x = rnd_bcd(); y = rnd_bcd();
      r = ref_add(x, y);
      run_add(x, y, r[15:0], r[16], 1'b0, DIGITS);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", nchk, nfail);
    $finish;
  end
endmodule
